bus_responder_6502: RTL and testbench

- Memory-side responder for the 6502 core bus (AB/DO/WE in, DI/RDY out); it replaces an ad-hoc bench memory in core-level simulation and FPGA bring-up.
- Contains a synchronous RAM, a fixed vector ROM and a wait-stated slow region that throttles the CPU via RDY.
- Also provides a halt/exit-code mailbox so software can end a run deterministically.

---
 rtl/bus_responder_6502.sv | 143 ++++++++++++++
 tb/tb_bus_responder_6502.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder_6502.sv
// bus_responder_6502: 6502 bus memory responder (RAM, vector ROM, wait-stated slow region, halt mailbox); access counters under `BUS_RESPONDER_STATS_EN
module bus_responder_6502 #(
    parameter int          RAM_AW      = 12,
    parameter logic [15:0] SLOW_BASE   = 16'h8000,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] RESET_VEC   = 16'hF000,
    parameter logic [15:0] IRQ_VEC     = 16'hF100,
    parameter logic [15:0] HALT_ADDR   = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        halted,
    output logic [7:0]  exit_code,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

    logic [7:0] mem [2**RAM_AW];
    logic [RAM_AW-1:0] ram_a;
    logic is_ram, is_vec, is_slow, acc, slow_go, ram_we;
    logic [15:0] vec;
    logic [7:0] fast_rd;
    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] di_q, di_d, sdat_q, sdat_d, exit_q, exit_d;
    logic swe_q, swe_d, halted_q, halted_d;

    // region decode and fast-path read data for the access presented on AB
    always_comb begin
        ram_a = AB[RAM_AW-1:0];
        is_ram = (AB >> RAM_AW) == 16'd0;
        is_vec = AB >= 16'hFFFA;
        is_slow = !is_ram && !is_vec && AB >= SLOW_BASE;
        acc = state_q == IDLE;
        slow_go = acc && is_slow && WAIT_STATES != 0;
        ram_we = acc && WE && is_ram;
        vec = (AB[2:1] == 2'b10) ? RESET_VEC : IRQ_VEC;
        fast_rd = is_ram ? mem[ram_a] :
                  is_vec ? (AB[0] ? vec[15:8] : vec[7:0]) :
                  is_slow ? AB[7:0] ^ 8'hA5 : di_q;
    end

    // accept in IDLE, park slow accesses in WAIT until the wait counter expires
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        di_d = di_q;
        sdat_d = sdat_q;
        swe_d = swe_q;
        halted_d = halted_q;
        exit_d = exit_q;
        if (acc) begin
            if (slow_go) begin
                state_d = WAIT;
                cnt_d = WS_M1;
                sdat_d = AB[7:0] ^ 8'hA5;
                swe_d = WE;
            end else begin
                di_d = WE ? di_q : fast_rd;
            end
            if (WE && AB == HALT_ADDR) begin
                halted_d = 1'b1;
                exit_d = DO;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
                di_d = swe_q ? di_q : sdat_q;
            end
        end
    end

    // control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            di_q <= 8'h00;
            sdat_q <= 8'h00;
            swe_q <= 1'b0;
            halted_q <= 1'b0;
            exit_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            di_q <= di_d;
            sdat_q <= sdat_d;
            swe_q <= swe_d;
            halted_q <= halted_d;
            exit_q <= exit_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_a] <= DO;
    end

    assign DI = di_q;
    assign RDY = state_q == IDLE;
    assign halted = halted_q;
    assign exit_code = exit_q;

`ifdef BUS_RESPONDER_STATS_EN
    logic done, done_we;
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    // count each access once on the edge where it completes, saturating at all-ones
    always_comb begin
        done = acc ? !slow_go : (cnt_q == 4'd0);
        done_we = acc ? WE : swe_q;
        rd_cnt_d = rd_cnt_q + 16'(done && !done_we && rd_cnt_q != 16'hFFFF);
        wr_cnt_d = wr_cnt_q + 16'(done && done_we && wr_cnt_q != 16'hFFFF);
    end

    // counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_bus_responder_6502.sv
// tb_bus_responder_6502: directed vector table, reset/saturation sequences and randomized accesses against a transaction-level model
module tb_bus_responder_6502;
    localparam int W = 2;
`ifdef BUS_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, WE = 1'b0;
    logic [15:0] AB = 16'h0000;
    logic [7:0] DO = 8'h00;
    logic [7:0] DI, DI0, exit_code, exit0;
    logic RDY, RDY0, halted, halted0;
    logic [15:0] rd_count, wr_count, rd0, wr0;

    bus_responder_6502 #(.WAIT_STATES(W)) dut (
        .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .halted(halted), .exit_code(exit_code), .rd_count(rd_count), .wr_count(wr_count));

    bus_responder_6502 #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .DI(DI0), .RDY(RDY0),
        .halted(halted0), .exit_code(exit0), .rd_count(rd0), .wr_count(wr0));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, rdy0_lows = 0;

    logic [7:0] m_mem [4096];
    logic [7:0] m_di, m_exit;
    logic m_halt;
    int m_rd, m_wr;

    typedef struct {
        logic we;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] di;
        int waits;
        logic h;
        logic [7:0] ex;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_di = 8'h00;
        m_halt = 1'b0;
        m_exit = 8'h00;
        m_rd = 0;
        m_wr = 0;
    endtask

    task automatic model(input logic [15:0] a, input logic we, input logic [7:0] d, output int waits);
        logic [15:0] v;
        waits = 0;
        v = (a == 16'hFFFC || a == 16'hFFFD) ? 16'hF000 : 16'hF100;
        if (a < 16'h1000) begin
            if (we) begin
                m_mem[a[11:0]] = d;
                if (a == 16'h0200) begin
                    m_halt = 1'b1;
                    m_exit = d;
                end
            end else m_di = m_mem[a[11:0]];
        end else if (a >= 16'hFFFA) begin
            if (!we) m_di = a[0] ? v[15:8] : v[7:0];
        end else if (a >= 16'h8000) begin
            waits = W;
            if (!we) m_di = a[7:0] ^ 8'hA5;
        end
        if (we) m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
        else m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
    endtask

    task automatic access(input logic [15:0] a, input logic we, input logic [7:0] d,
                          output logic [7:0] di, output int waits);
        AB = a;
        WE = we;
        DO = d;
        @(posedge clk);
        waits = 0;
        do begin
            @(negedge clk);
            if (!RDY0) rdy0_lows++;
            if (!RDY) waits++;
        end while (!RDY && waits <= 20);
        if (!RDY) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: RDY still low after %0d cycles at addr %h", waits, a);
        end
        di = DI;
    endtask

    task automatic chk_counts(input string n);
        chk({n, "_rd_count"}, rd_count, STATS ? 32'(m_rd) : 32'h0);
        chk({n, "_wr_count"}, wr_count, STATS ? 32'(m_wr) : 32'h0);
    endtask

    initial begin
        logic [7:0] got, d;
        logic [15:0] a;
        logic we;
        int w, mw;
        tbl[0]  = '{1'b0, 16'hFFFC, 8'h00, 8'h00, 0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 16'hFFFD, 8'h00, 8'hF0, 0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 16'h0123, 8'h5A, 8'hF0, 0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 16'h0123, 8'h00, 8'h5A, 0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 16'h2000, 8'h00, 8'h5A, 0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 16'hFFFC, 8'h77, 8'h5A, 0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 16'hFFFC, 8'h00, 8'h00, 0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 16'h8034, 8'h00, 8'h91, 2, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 16'h8034, 8'h11, 8'h91, 2, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 16'hFFFB, 8'h00, 8'hF1, 0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 16'hFFFE, 8'h00, 8'h00, 0, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 16'h0200, 8'h42, 8'h00, 0, 1'b1, 8'h42};
        tbl[12] = '{1'b0, 16'h0200, 8'h00, 8'h42, 0, 1'b1, 8'h42};
        tbl[13] = '{1'b1, 16'h0200, 8'h07, 8'h42, 0, 1'b1, 8'h07};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rdy", RDY, 1);
        chk("reset_di", DI, 8'h00);
        chk("reset_halted", halted, 0);
        chk("reset_exit", exit_code, 8'h00);
        chk_counts("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            access(tbl[i].a, tbl[i].we, tbl[i].d, got, w);
            model(tbl[i].a, tbl[i].we, tbl[i].d, mw);
            chk($sformatf("tbl%0d_di", i), got, tbl[i].di);
            chk($sformatf("tbl%0d_waits", i), w, tbl[i].waits);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].h);
            chk($sformatf("tbl%0d_exit", i), exit_code, tbl[i].ex);
            chk($sformatf("tbl%0d_di_ws0", i), DI0, tbl[i].di);
            chk($sformatf("tbl%0d_halted_ws0", i), halted0, tbl[i].h);
        end
        chk("ws0_rdy_never_low", rdy0_lows, 0);
        chk_counts("tbl");

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            access(16'h0300 + 16'(i), 1'b1, d, got, w);
            model(16'h0300 + 16'(i), 1'b1, d, mw);
        end
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: a = 16'h0300 + 16'($urandom_range(15));
                1: a = 16'hFFFA + 16'($urandom_range(5));
                2: a = 16'($urandom_range(16'hFFF9, 16'h8000));
                default: a = 16'($urandom_range(16'h7FFF, 16'h1000));
            endcase
            we = 1'($urandom_range(1));
            d = 8'($urandom);
            access(a, we, d, got, w);
            model(a, we, d, mw);
            chk($sformatf("rnd%0d_di@%h", i, a), got, m_di);
            chk($sformatf("rnd%0d_waits@%h", i, a), w, mw);
            chk($sformatf("rnd%0d_halted", i), halted, m_halt);
            chk($sformatf("rnd%0d_exit", i), exit_code, m_exit);
        end
        chk_counts("rnd");

        AB = 16'h8034;
        WE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midwait_rdy_low", RDY, 0);
        #1 reset = 1'b1;
        #1;
        chk("midwait_reset_rdy", RDY, 1);
        chk("midwait_reset_di", DI, 8'h00);
        chk("midwait_reset_halted", halted, 0);
        chk("midwait_reset_exit", exit_code, 8'h00);
        model_reset();
        chk_counts("midwait_reset");
        @(negedge clk);
        reset = 1'b0;
        access(16'h0123, 1'b0, 8'h00, got, w);
        model(16'h0123, 1'b0, 8'h00, mw);
        chk("ram_kept_di", got, 8'h5A);
        chk("ram_kept_waits", w, 0);
        chk_counts("post_reset");

`ifdef BUS_RESPONDER_STATS_EN
        force dut.rd_cnt_q = 16'hFFFF;
        #1 release dut.rd_cnt_q;
        access(16'hFFFD, 1'b0, 8'h00, got, w);
        chk("sat_rd_count", rd_count, 16'hFFFF);
        chk("sat_di", got, 8'hF0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
